// File: rtl/mips32_mem_arbiter.sv
// mips32_mem_arbiter: shares one single-port memory between loader, MEM stage and fetch.
module mips32_mem_arbiter #(
    parameter int AW = 10,
    parameter int DW = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk1,
    input  logic          reset,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    typedef enum logic [1:0] {O_NONE, O_DBG, O_DM, O_IF} owner_t;
    state_t state, state_n;
    owner_t owner, winner;
    logic [3:0] starve, starve_n;
    logic arb, win_we, live;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    always_comb begin
        arb = state != ISSUE;
        winner = dbg_req ? O_DBG : (if_req && starve == 4'(STARVE_LIMIT)) ? O_IF :
                 dm_req ? O_DM : if_req ? O_IF : O_NONE;
        win_we = winner == O_DBG ? dbg_we : winner == O_DM ? dm_we : 1'b0;
        win_addr = winner == O_DBG ? dbg_addr : winner == O_DM ? dm_addr : if_addr;
        win_wdata = winner == O_DBG ? dbg_wdata : winner == O_DM ? dm_wdata : '0;
        starve_n = (!if_req || winner == O_IF) ? 4'd0 :
                   (winner == O_DM && starve != 4'(STARVE_LIMIT)) ? starve + 4'd1 : starve;
        state_n = arb ? (winner != O_NONE ? ISSUE : IDLE) : (mem_we ? IDLE : RESP);
    end
    always_ff @(posedge clk1) begin
        if (reset) begin
            state <= IDLE;
            owner <= O_NONE;
            starve <= '0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
        end else begin
            state <= state_n;
            mem_en <= arb && winner != O_NONE;
            mem_we <= arb && win_we;
            if (arb) begin
                owner <= winner;
                starve <= starve_n;
                if (winner != O_NONE) begin
                    mem_addr <= win_addr;
                    mem_wdata <= win_wdata;
                end
            end
        end
    end
    // Reset masks grant/response of an aborted access in the cycle it is asserted.
    assign live = !reset;
    assign dbg_gnt = live && state == ISSUE && owner == O_DBG;
    assign dm_gnt = live && state == ISSUE && owner == O_DM;
    assign if_gnt = live && state == ISSUE && owner == O_IF;
    assign dbg_rvalid = live && state == RESP && owner == O_DBG;
    assign dm_rvalid = live && state == RESP && owner == O_DM;
    assign if_rvalid = live && state == RESP && owner == O_IF;
    assign rdata = (live && state == RESP) ? mem_rdata : '0;
    assign busy = state != IDLE;
endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// tb_mips32_mem_arbiter: scoreboard bench with a transaction-level arbitration model.
module tb_mips32_mem_arbiter;
    localparam int SL = 4;
    logic clk1 = 0, reset = 1;
    logic dbg_req = 0, dbg_we = 0, dm_req = 0, dm_we = 0, if_req = 0;
    logic [9:0] dbg_addr = 0, dm_addr = 0, if_addr = 0;
    logic [31:0] dbg_wdata = 0, dm_wdata = 0;
    logic dbg_gnt, dbg_rvalid, dm_gnt, dm_rvalid, if_gnt, if_rvalid, mem_en, mem_we, busy;
    logic [9:0] mem_addr;
    logic [31:0] mem_wdata, rdata, mem_rdata;
    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];
    typedef struct {int who; logic we; logic [9:0] addr; logic [31:0] data;} txn_t;
    typedef struct {int who; logic [31:0] data;} rsp_t;
    txn_t pred_g = '{0, 1'b0, 10'd0, 32'd0};
    int pred_rv = 0, starve_m = 0;
    rsp_t resp_q[$];
    int gseq[$];
    int total = 0, fails = 0;
    int p_dbg = 0, p_dm = 0, p_if = 0, wpct = 50;

    mips32_mem_arbiter #(.AW(10), .DW(32), .STARVE_LIMIT(SL)) dut (
        .clk1(clk1), .reset(reset),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk1 = ~clk1;

    always @(posedge clk1) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] vec(input int w);
        return w == 1 ? 3'b100 : w == 2 ? 3'b010 : w == 3 ? 3'b001 : 3'b000;
    endfunction

    // Monitor + reference model: every cycle without a predicted grant is an arbitration point.
    always @(negedge clk1) begin
        logic [2:0] gv, rv;
        int eg, er, w;
        rsp_t r;
        eg = reset ? 0 : pred_g.who;
        er = reset ? 0 : pred_rv;
        gv = {dbg_gnt, dm_gnt, if_gnt};
        rv = {dbg_rvalid, dm_rvalid, if_rvalid};
        chk("gnt", 32'(gv), 32'(vec(eg)));
        chk("rvalid", 32'(rv), 32'(vec(er)));
        chk("busy", 32'(busy), 32'(pred_g.who != 0 || pred_rv != 0));
        chk("mem_en", 32'(mem_en), 32'(pred_g.who != 0));
        if (pred_g.who != 0) begin
            chk("mem_we", 32'(mem_we), 32'(pred_g.we));
            chk("mem_addr", 32'(mem_addr), 32'(pred_g.addr));
            if (pred_g.we) chk("mem_wdata", mem_wdata, pred_g.data);
        end
        if (gv != 0) gseq.push_back(dbg_gnt ? 1 : dm_gnt ? 2 : 3);
        if (rv != 0) begin
            if (resp_q.size() == 0) chk("rsp_pending", 32'(rv), 32'd0);
            else begin
                r = resp_q.pop_front();
                chk("rsp_owner", 32'(rv), 32'(vec(r.who)));
                chk("rdata", rdata, r.data);
            end
        end else chk("rdata_idle", rdata, 32'd0);
        if (reset) begin
            pred_g.who = 0;
            pred_rv = 0;
            starve_m = 0;
            resp_q.delete();
        end else if (pred_g.who != 0) begin
            pred_rv = pred_g.we ? 0 : pred_g.who;
            pred_g.who = 0;
        end else begin
            pred_rv = 0;
            w = dbg_req ? 1 : (if_req && starve_m >= SL) ? 3 : dm_req ? 2 : if_req ? 3 : 0;
            if (!if_req || w == 3) starve_m = 0;
            else if (w == 2 && starve_m < SL) starve_m++;
            pred_g.who = w;
            pred_g.we = w == 1 ? dbg_we : w == 2 ? dm_we : 1'b0;
            pred_g.addr = w == 1 ? dbg_addr : w == 2 ? dm_addr : if_addr;
            pred_g.data = w == 1 ? dbg_wdata : w == 2 ? dm_wdata : 32'd0;
            if (w != 0) begin
                if (pred_g.we) ref_mem[pred_g.addr] = pred_g.data;
                else resp_q.push_back('{w, ref_mem[pred_g.addr]});
            end
        end
    end

    task automatic step();
        @(posedge clk1);
        #1;
        if (dbg_req && dbg_gnt) dbg_req = 0;
        if (dm_req && dm_gnt) dm_req = 0;
        if (if_req && if_gnt) if_req = 0;
        if (!dbg_req && int'($urandom_range(99)) < p_dbg) begin
            dbg_req = 1; dbg_we = 1'($urandom); dbg_addr = 10'($urandom); dbg_wdata = $urandom;
        end
        if (!dm_req && int'($urandom_range(99)) < p_dm) begin
            dm_req = 1; dm_we = int'($urandom_range(99)) < wpct; dm_addr = 10'($urandom); dm_wdata = $urandom;
        end
        if (!if_req && int'($urandom_range(99)) < p_if) begin
            if_req = 1; if_addr = 10'($urandom);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n;
        int e2[3];
        int e3[6];
        e2 = '{1, 2, 3};
        e3 = '{2, 2, 2, 2, 3, 2};
        for (int i = 0; i < 1024; i++) begin
            logic [31:0] v;
            v = $urandom;
            mem[i] <= v;
            ref_mem[i] = v;
        end
        mem[120] <= 32'd85;
        ref_mem[120] = 32'd85;
        repeat (3) @(posedge clk1);
        #1;
        reset = 0;
        dm_req = 1; dm_we = 0; dm_addr = 10'd120;
        #3;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        step(); #3;
        chk("t1_dm_gnt", 32'(dm_gnt), 1);
        chk("t1_mem_addr", 32'(mem_addr), 120);
        chk("t1_busy1", 32'(busy), 1);
        step(); #3;
        chk("t1_dm_rvalid", 32'(dm_rvalid), 1);
        chk("t1_rdata", rdata, 85);
        chk("t1_busy2", 32'(busy), 1);
        steps(2);

        base = gseq.size();
        dbg_req = 1; dbg_we = 1; dbg_addr = 10'd7; dbg_wdata = 32'h00832800;
        dm_req = 1; dm_we = 0; dm_addr = 10'd5;
        if_req = 1; if_addr = 10'd9;
        steps(10);
        chk("t2_len", 32'(gseq.size() - base), 3);
        if (gseq.size() - base >= 3)
            for (int k = 0; k < 3; k++) chk("t2_order", 32'(gseq[base + k]), 32'(e2[k]));
        chk("t2_mem7", mem[7], 32'h00832800);

        base = gseq.size();
        p_dm = 100; p_if = 100; wpct = 0;
        steps(25);
        p_dm = 0; p_if = 0; wpct = 50;
        steps(8);
        chk("t3_len", 32'(gseq.size() - base >= 6), 1);
        if (gseq.size() - base >= 6)
            for (int k = 0; k < 6; k++) chk("t3_starve_order", 32'(gseq[base + k]), 32'(e3[k]));

        dm_req = 1; dm_we = 1; dm_addr = 10'd121; dm_wdata = 32'd130;
        steps(3);
        chk("t4_mem121", mem[121], 32'd130);
        dm_req = 1; dm_we = 0; dm_addr = 10'd121;
        steps(4);

        if_req = 1; if_addr = 10'd33;
        step(); step();
        reset = 1;
        #3;
        chk("t5_if_rvalid", 32'(if_rvalid), 0);
        chk("t5_rdata", rdata, 0);
        step();
        reset = 0;
        #3;
        chk("t5_outs", {busy, mem_en, mem_we, dbg_gnt, dm_gnt, if_gnt, if_rvalid}, 0);
        chk("t5_mem_addr", 32'(mem_addr), 0);
        chk("t5_mem_wdata", mem_wdata, 0);
        steps(2);

        for (int a = 0; a < 3; a++) begin
            if_req = 1; if_addr = 10'(a);
            n = 0;
            do begin step(); n++; end while (!if_gnt && n < 10);
            chk("t6_gnt_gap", 32'(n), a == 0 ? 32'd1 : 32'd2);
        end
        steps(3);

        p_dbg = 15; p_dm = 40; p_if = 60;
        steps(1500);
        p_dbg = 0; p_dm = 0; p_if = 0;
        steps(12);
        chk("drain_resp_q", 32'(resp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, fails);
        $finish;
    end
endmodule
